switch_debounce: RTL and testbench

- Conditions raw board push-buttons before they reach the counter/display logic, such as the counter-reset input of the 1 Hz display counter.
- Per channel it synchronises the asynchronous switch and removes contact bounce.
- Per channel it produces a clean level, a single-cycle press pulse, a single-cycle release pulse and a single-cycle long-press pulse.
- Sits directly between the board switch pins and every consumer of button input.

---
 rtl/switch_debounce.sv | 109 ++++++++++
 tb/tb_switch_debounce.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce raw push-buttons into clean level, press, release and long-press pulses.
// Ports:
//   i_Clk           system clock
//   i_Rst_L         synchronous reset, active-low
//   i_Switch        raw asynchronous switch inputs, 1 = pressed
//   o_Level         debounced level per channel
//   o_Press_Pulse   one-cycle pulse when a debounced press is accepted
//   o_Release_Pulse one-cycle pulse when a debounced release is accepted
//   o_Long_Pulse    one-cycle pulse, once per press, when hold time reaches LONG_PRESS_CYCLES
module switch_debounce #(
  parameter int NUM_SW            = 4,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Level,
  output logic [NUM_SW-1:0] o_Press_Pulse,
  output logic [NUM_SW-1:0] o_Release_Pulse,
  output logic [NUM_SW-1:0] o_Long_Pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_PRESS_CYCLES);
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;
  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    logic          s1_q, s2_q;
    state_t        state_q;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_d;
    logic          level_q, press_q, release_q, long_q;
    // Hold counter saturates, so the long pulse fires only on the single transition into H_MAX.
    always_comb begin
      dcnt_d = dcnt_q + 1'b1;
      hcnt_d = (hcnt_q == H_MAX) ? hcnt_q : hcnt_q + 1'b1;
      long_d = (hcnt_q != H_MAX) && (hcnt_d == H_MAX);
    end
    always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= RELEASED;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        s1_q      <= i_Switch[g];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          RELEASED: begin
            dcnt_q <= s2_q ? D_ONE : '0;
            if (s2_q) state_q <= PRESS_CHK;
          end
          PRESS_CHK: begin
            if (!s2_q) begin
              state_q <= RELEASED;
              dcnt_q  <= '0;
            end else if (dcnt_q == D_LAST) begin
              state_q <= PRESSED;
              level_q <= 1'b1;
              press_q <= 1'b1;
              hcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_d;
            end
          end
          PRESSED: begin
            hcnt_q <= hcnt_d;
            long_q <= long_d;
            if (!s2_q) begin
              state_q <= RELEASE_CHK;
              dcnt_q  <= D_ONE;
            end
          end
          RELEASE_CHK: begin
            // Hold time keeps running so a rejected release glitch does not disturb long-press timing.
            hcnt_q <= hcnt_d;
            long_q <= long_d;
            if (s2_q) begin
              state_q <= PRESSED;
              dcnt_q  <= '0;
            end else if (dcnt_q == D_LAST) begin
              state_q   <= RELEASED;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_d;
            end
          end
          default: state_q <= RELEASED;
        endcase
      end
    end
    assign o_Level[g]         = level_q;
    assign o_Press_Pulse[g]   = press_q;
    assign o_Release_Pulse[g] = release_q;
    assign o_Long_Pulse[g]    = long_q;
  end
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: table-driven and sequence checks of switch_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20.
module tb_switch_debounce;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] level, press, rel, lng;
  int checks = 0;
  int errors = 0;
  int press_n, long_n, rel_n, press_at, long_at, rel_at, lvl_bad;
  typedef struct packed {
    logic       rst_l;
    logic [1:0] sw;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } vec_t;
  vec_t vecs[$];

  switch_debounce #(.NUM_SW(N), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20)) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .i_Switch(sw),
    .o_Level(level),
    .o_Press_Pulse(press),
    .o_Release_Pulse(rel),
    .o_Long_Pulse(lng)
  );

  always #5 clk = ~clk;

  task automatic add(input int n, input logic r, input logic [1:0] s, input logic [1:0] l,
                     input logic [1:0] p, input logic [1:0] rl, input logic [1:0] lg);
    vec_t v;
    v.rst_l = r; v.sw = s; v.level = l; v.press = p; v.rel = rl; v.lng = lg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] s);
    rst_l = r;
    sw = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear();
    press_n = 0; long_n = 0; rel_n = 0;
    press_at = -1; long_at = -1; rel_at = -1; lvl_bad = 0;
  endtask

  task automatic record(input int c, input int ch);
    if (press[ch]) begin press_n++; press_at = c; end
    if (lng[ch]) begin long_n++; long_at = c; end
    if (rel[ch]) begin rel_n++; rel_at = c; end
  endtask

  initial begin
    // reset with both switches held, then simultaneous press and release
    add(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);
    add(2, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // bounce on channel 0: 1,0,1,0,1 then steady 1
    add(1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    // short press released well before the long-press threshold
    add(5, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_l, vecs[i].sw);
      check($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].level));
      check($sformatf("v%0d press", i), 32'(press), 32'(vecs[i].press));
      check($sformatf("v%0d release", i), 32'(rel), 32'(vecs[i].rel));
      check($sformatf("v%0d long", i), 32'(lng), 32'(vecs[i].lng));
    end

    // long press: held 40 cycles, one long pulse 20 cycles after the press pulse
    clear();
    for (int c = 0; c < 60; c++) begin
      step(1'b1, c < 40 ? 2'b01 : 2'b00);
      record(c, 0);
    end
    check("long press_at", press_at, 5);
    check("long press_n", press_n, 1);
    check("long long_n", long_n, 1);
    check("long delay", long_at - press_at, 20);
    check("long rel_at", rel_at, 45);
    check("long end level", 32'(level), 0);

    // release glitch: two low cycles while pressed are rejected, hold count continues
    clear();
    for (int c = 0; c < 50; c++) begin
      step(1'b1, (c < 30 && c != 12 && c != 13) ? 2'b01 : 2'b00);
      record(c, 0);
      if (c >= 5 && c < 35 && !level[0]) lvl_bad++;
    end
    check("glitch press_at", press_at, 5);
    check("glitch level drops", lvl_bad, 0);
    check("glitch rel_n", rel_n, 1);
    check("glitch rel_at", rel_at, 35);
    check("glitch long_n", long_n, 1);
    check("glitch long_at", long_at, 25);

    // reset mid-hold on channel 1 at hold count 10
    clear();
    for (int c = 0; c < 50; c++) begin
      step(c == 16 || c == 17 ? 1'b0 : 1'b1, c < 18 ? 2'b10 : 2'b00);
      record(c, 1);
      if (c == 15) check("rst pre level", 32'(level), 2);
      if (c >= 16 && level != 2'b00) lvl_bad++;
    end
    check("rst press_at", press_at, 5);
    check("rst level after", lvl_bad, 0);
    check("rst rel_n", rel_n, 0);
    check("rst long_n", long_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
